topk_tracker: RTL and testbench

- Parametrised successor to the fixed third-largest tracker.
- Collects a framed burst of COUNT samples, usually ALU results, and keeps a sorted table of the K most extreme values.
- Extreme means largest or smallest, selected per burst; ties are either merged (distinct) or kept (duplicates), also per burst.
- At end of burst it reports the entry at a runtime-selected rank plus a found flag. Sits between the ALU datapath and the result/status registers.

---
 rtl/topk_pkg.sv | 18 +
 rtl/topk_insert_net.sv | 53 +++++
 rtl/topk_tracker.sv | 99 +++++++++
 tb/tb_topk_tracker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/topk_pkg.sv
// Shared types and defaults for the top-K tracker and its insertion network.
package topk_pkg;

    localparam int TOPK_DATA_W = 8;
    localparam int TOPK_K      = 4;
    localparam int TOPK_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int rank_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/topk_insert_net.sv
// Single-sample sorted insert into a K-deep table; purely combinational (0 cycles).
// No flow control: the caller decides whether to commit the next table.
module topk_insert_net
    import topk_pkg::*;
#(
    parameter int DATA_W = TOPK_DATA_W,
    parameter int K      = TOPK_K
) (
    input  logic [K-1:0][DATA_W-1:0] tbl,
    input  logic [K-1:0]             occ,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     mode_min,
    input  logic                     allow_dup,
    output logic [K-1:0][DATA_W-1:0] tbl_nxt,
    output logic [K-1:0]             occ_nxt
);

    logic [K-1:0] better;
    logic [K-1:0] equal;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            equal[i]  = occ[i] && (tbl[i] == data_in);
            better[i] = !occ[i] || (mode_min ? (data_in < tbl[i]) : (data_in > tbl[i]));
        end
    end

    // Strict comparison means an equal value lands after its equals, keeping dup ordering stable.
    always_comb begin
        logic ins;
        ins     = 1'b0;
        tbl_nxt = tbl;
        occ_nxt = occ;
        if (allow_dup || !(|equal)) begin
            if (better[0]) begin
                tbl_nxt[0] = data_in;
                occ_nxt[0] = 1'b1;
                ins        = 1'b1;
            end
            for (int j = 1; j < K; j++) begin
                if (ins) begin
                    tbl_nxt[j] = tbl[j-1];
                    occ_nxt[j] = occ[j-1];
                end else if (better[j]) begin
                    tbl_nxt[j] = data_in;
                    occ_nxt[j] = 1'b1;
                    ins        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/topk_tracker.sv
// Tracks the K most extreme samples of a framed burst and reports one rank at end of burst.
// finish pulses 2 cycles after the last accepted sample; no backpressure, extra valids are ignored.
module topk_tracker
    import topk_pkg::*;
#(
    parameter int DATA_W = TOPK_DATA_W,
    parameter int K      = TOPK_K,
    parameter int CNT_W  = TOPK_CNT_W,
    parameter int RANK_W = rank_width(K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              mode_min,
    input  logic              allow_dup,
    input  logic              valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [RANK_W-1:0] rank_sel,
    output logic              busy,
    output logic              finish,
    output logic [DATA_W-1:0] result,
    output logic              found
);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_lat;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      mode_lat;
    logic                      dup_lat;
    logic [K-1:0][DATA_W-1:0]  tbl;
    logic [K-1:0]              occ;
    logic [K-1:0][DATA_W-1:0]  tbl_nxt;
    logic [K-1:0]              occ_nxt;
    logic                      rank_hit;

    topk_insert_net #(
        .DATA_W (DATA_W),
        .K      (K)
    ) u_insert (
        .tbl       (tbl),
        .occ       (occ),
        .data_in   (data_in),
        .mode_min  (mode_lat),
        .allow_dup (dup_lat),
        .tbl_nxt   (tbl_nxt),
        .occ_nxt   (occ_nxt)
    );

    assign cnt_inc  = cnt + CNT_W'(1);
    assign busy     = (state != ST_IDLE);
    assign rank_hit = (int'(rank_sel) < K) && occ[rank_sel];

    // The DONE snapshot reads the old table before a same-cycle start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cnt_lat  <= '0;
            mode_lat <= 1'b0;
            dup_lat  <= 1'b0;
            tbl      <= '0;
            occ      <= '0;
            finish   <= 1'b0;
            result   <= '0;
            found    <= 1'b0;
        end else begin
            finish <= (state == ST_DONE);
            if (state == ST_DONE) begin
                result <= rank_hit ? tbl[rank_sel] : '0;
                found  <= rank_hit;
            end
            if (start) begin
                cnt_lat  <= count;
                mode_lat <= mode_min;
                dup_lat  <= allow_dup;
                tbl      <= '0;
                occ      <= '0;
                cnt      <= '0;
                state    <= (count == '0) ? ST_DONE : ST_COLLECT;
            end else begin
                case (state)
                    ST_COLLECT: begin
                        if (valid) begin
                            tbl <= tbl_nxt;
                            occ <= occ_nxt;
                            cnt <= cnt_inc;
                            if (cnt_inc == cnt_lat) state <= ST_DONE;
                        end
                    end
                    ST_DONE:  state <= ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_topk_tracker.sv
// Randomised and directed bench for topk_tracker against a sort-based reference model.
module tb_topk_tracker;

    localparam int K = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] count;
    logic       mode_min;
    logic       allow_dup;
    logic       valid;
    logic [7:0] data_in;
    logic [1:0] rank_sel;
    logic       busy;
    logic       finish;
    logic [7:0] result;
    logic       found;

    int vectors = 0;
    int errors  = 0;
    int fin_cnt = 0;

    topk_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .mode_min  (mode_min),
        .allow_dup (allow_dup),
        .valid     (valid),
        .data_in   (data_in),
        .rank_sel  (rank_sel),
        .busy      (busy),
        .finish    (finish),
        .result    (result),
        .found     (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: sort the burst, optionally drop repeats, keep the first K, pick the rank.
    function automatic void lookup(input int s[$], input bit mn, input bit dp, input int rank,
                                   output int res, output bit fnd);
        int t[$];
        int u[$];
        t = s;
        if (mn) t.sort();
        else    t.rsort();
        foreach (t[i]) begin
            if (dp || u.size() == 0 || u[u.size()-1] != t[i]) u.push_back(t[i]);
        end
        while (u.size() > K) void'(u.pop_back());
        if (rank < u.size()) begin
            res = u[rank];
            fnd = 1'b1;
        end else begin
            res = 0;
            fnd = 1'b0;
        end
    endfunction

    // Model: phase 0 idle, 1 collecting, 2 reporting.
    int  m_phase;
    int  m_target;
    int  m_acc;
    bit  m_min;
    bit  m_dup;
    int  m_q[$];
    int  m_res;
    bit  m_fnd;
    bit  exp_busy;
    bit  exp_finish;
    int  exp_result;
    bit  exp_found;

    task model_begin();
        m_target = int'(count);
        m_min    = mode_min;
        m_dup    = allow_dup;
        m_q.delete();
        m_acc    = 0;
        m_phase  = (m_target == 0) ? 2 : 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_phase    = 0;
            m_acc      = 0;
            m_q.delete();
            exp_finish = 1'b0;
            exp_result = 0;
            exp_found  = 1'b0;
        end else begin
            exp_finish = 1'b0;
            if (m_phase == 2) begin
                lookup(m_q, m_min, m_dup, int'(rank_sel), m_res, m_fnd);
                exp_result = m_res;
                exp_found  = m_fnd;
                exp_finish = 1'b1;
                m_phase    = 0;
                if (start) model_begin();
            end else if (start) begin
                model_begin();
            end else if (m_phase == 1 && valid) begin
                m_q.push_back(int'(data_in));
                m_acc++;
                if (m_acc == m_target) m_phase = 2;
            end
        end
        exp_busy = (m_phase != 0);
    end

    always @(negedge clk) begin
        chk("busy",   busy,   exp_busy);
        chk("finish", finish, exp_finish);
        chk("result", result, exp_result);
        chk("found",  found,  exp_found);
        if (finish === 1'b1) fin_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(output int res, output bit fnd, output int lat);
        for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (finish === 1'b1) break;
        end
        res = int'(result);
        fnd = found;
        step();
    endtask

    task automatic burst(input int cnt, input bit mn, input bit dp, input int rk, input int s[$],
                         input int gap, output int res, output bit fnd, output int lat);
        start = 1'b1; count = 8'(cnt); mode_min = mn; allow_dup = dp;
        rank_sel = 2'(rk); valid = 1'b0;
        step();
        start = 1'b0;
        foreach (s[i]) begin
            data_in = 8'(s[i]);
            valid   = 1'b1;
            step();
            valid   = 1'b0;
            if (i != s.size() - 1) repeat (gap) step();
        end
        wait_fin(res, fnd, lat);
    endtask

    int smp[$];
    int res;
    bit fnd;
    int lat;
    int f0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; mode_min = 1'b0; allow_dup = 1'b0;
        valid = 1'b0; data_in = '0; rank_sel = '0;
        repeat (2) step();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_found", found, 0);

        // Max, distinct: table {9,7,5,2}
        smp = '{5, 9, 9, 2, 7, 1};
        burst(6, 0, 0, 2, smp, 0, res, fnd, lat);
        chk("max_dist_r2", res, 5); chk("max_dist_r2_found", fnd, 1); chk("max_dist_lat", lat, 2);
        burst(6, 0, 0, 0, smp, 0, res, fnd, lat);
        chk("max_dist_r0", res, 9);
        burst(6, 0, 0, 3, smp, 1, res, fnd, lat);
        chk("max_dist_r3", res, 2); chk("max_dist_r3_found", fnd, 1);

        // Max, duplicates: table {9,9,7,5}
        burst(6, 0, 1, 1, smp, 0, res, fnd, lat);
        chk("max_dup_r1", res, 9); chk("max_dup_r1_found", fnd, 1);
        burst(6, 0, 1, 2, smp, 0, res, fnd, lat);
        chk("max_dup_r2", res, 7);

        // Min, distinct: table {3,8}
        smp = '{8, 3, 3, 3};
        burst(4, 1, 0, 1, smp, 0, res, fnd, lat);
        chk("min_dist_r1", res, 8); chk("min_dist_r1_found", fnd, 1);
        burst(4, 1, 0, 2, smp, 0, res, fnd, lat);
        chk("min_dist_r2", res, 0); chk("min_dist_r2_found", fnd, 0);

        // count == 0 with stray valids
        start = 1'b1; count = 8'd0; rank_sel = 2'd0;
        step();
        start = 1'b0; valid = 1'b1; data_in = 8'd77;
        wait_fin(res, fnd, lat);
        valid = 1'b0;
        chk("cnt0_lat", lat, 2); chk("cnt0_found", fnd, 0); chk("cnt0_result", res, 0);

        // Abort by start after 2 of 5 samples; same-cycle valid ignored
        f0 = fin_cnt;
        start = 1'b1; count = 8'd5; mode_min = 1'b0; allow_dup = 1'b0; rank_sel = 2'd0;
        step();
        start = 1'b0; valid = 1'b1; data_in = 8'd200; step();
        data_in = 8'd100; step();
        start = 1'b1; count = 8'd3; data_in = 8'd250; step();
        start = 1'b0; data_in = 8'd1; step();
        data_in = 8'd4; step();
        data_in = 8'd6; step();
        valid = 1'b0;
        wait_fin(res, fnd, lat);
        chk("abort_result", res, 6); chk("abort_lat", lat, 2);
        chk("abort_single_finish", fin_cnt - f0, 1);

        // Reset mid-burst
        f0 = fin_cnt;
        start = 1'b1; count = 8'd5; step();
        start = 1'b0; valid = 1'b1; data_in = 8'd9; step();
        data_in = 8'd11; step();
        valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_busy", busy, 0); chk("rst_finish", finish, 0);
        chk("rst_result", result, 0); chk("rst_found", found, 0);
        repeat (6) step();
        chk("rst_no_finish", fin_cnt - f0, 0);

        // Back-to-back: start in the DONE cycle, then gapped samples
        start = 1'b1; count = 8'd2; mode_min = 1'b0; allow_dup = 1'b0; rank_sel = 2'd0;
        step();
        start = 1'b0; valid = 1'b1; data_in = 8'd3; step();
        data_in = 8'd8; step();
        valid = 1'b0; start = 1'b1; count = 8'd3; step();
        start = 1'b0; rank_sel = 2'd1;
        chk("b2b_old_finish", finish, 1); chk("b2b_old_result", result, 8);
        smp = '{10, 20, 15};
        foreach (smp[i]) begin
            data_in = 8'(smp[i]); valid = 1'b1; step();
            valid = 1'b0;
            if (i != 2) repeat (3) step();
        end
        wait_fin(res, fnd, lat);
        chk("b2b_new_result", res, 15); chk("b2b_new_lat", lat, 2);

        // Random bursts; the per-cycle compare does the checking
        for (int b = 0; b < 60; b++) begin
            int n;
            int hi;
            n  = $urandom_range(0, 10);
            hi = ($urandom_range(0, 1) == 1) ? 15 : 255;
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back($urandom_range(0, hi));
            burst(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  smp, $urandom_range(0, 2), res, fnd, lat);
            chk("rand_lat", lat, 2);
            if ($urandom_range(0, 2) == 0) begin
                valid = 1'b1; data_in = 8'($urandom_range(0, 255)); step();
                valid = 1'b0;
            end
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
